mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory module between two bus masters: the CPU controller (port 0) and a DMA/program-loader engine (port 1).
- Accepts one request per master. It arbitrates round-robin, then sequences the memory's address phase and data phase using `mem_addr_en`, `mem_in_en` and `mem_out_en`.
- It returns read data and a one-cycle acknowledge to the winning master.
- Sits between the masters and the memory in the tiny16 top level, on the 1 MHz domain.

Parameters:
- ADDR_W, 16, address width of memory and requester address ports
- DATA_W, 16, data width of memory and requester data ports

Ports:
- clk  input  1  system clock (1 MHz divided clock)
- rst  input  1  synchronous, active-high reset
- req0  input  1  port 0 (CPU) request; held high until ack0
- we0  input  1  port 0 write enable (1=write, 0=read); stable while req0
- addr0  input  ADDR_W  port 0 address; stable while req0
- wdata0  input  DATA_W  port 0 write data; stable while req0
- gnt0  output  1  port 0 owns memory (ADDR, DATA, DONE states)
- ack0  output  1  port 0 transfer complete, one-cycle pulse
- req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  port 1 (DMA), same rules as port 0
- gnt1, ack1  output  1/1  port 1 grant and acknowledge
- rdata  output  DATA_W  read data, valid while ack0 or ack1 is high for a read
- busy  output  1  high in any state other than IDLE
- mem_addr_en  output  1  memory address latch strobe
- mem_in_en  output  1  memory write strobe
- mem_out_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  address to memory
- mem_wdata  output  DATA_W  write data to memory
- mem_rdata  input  DATA_W  memory read output; valid in the same cycle as mem_out_en

Behaviour:
- All outputs are registered except mem_* strobes and gnt0/gnt1, which decode from the state register.
- All outputs are 0 after reset. The last_grant register resets to 1, so port 0 wins the first contention.
- FSM states: IDLE -> ADDR -> DATA -> DONE -> IDLE.
- IDLE:
  - Sample req0/req1.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port != last_grant.
  - On grant: latch winner id, we, addr and wdata into internal registers, update last_grant, go to ADDR.
- ADDR: mem_addr_en=1; mem_addr=latched addr; go to DATA.
- DATA:
  - Write: mem_in_en=1, mem_wdata=latched wdata.
  - Read: mem_out_en=1; capture mem_rdata into rdata at the end of the cycle.
  - Go to DONE.
- DONE: ack of the winner =1 for exactly this cycle; rdata holds the captured value (unchanged on writes); go to IDLE.
- mem_addr/mem_wdata show the latched values in ADDR and DATA, and 0 otherwise. Only one mem_* strobe is high at any time.
- Latency: a request sampled in IDLE at cycle N gives ack at cycle N+3. Throughput is one transfer per 4 cycles.
- Requester handshake:
  - The master drops req on the edge after seeing ack, so req is already low in the following IDLE.
  - A req still high in IDLE counts as a new request.
  - Changing we/addr/wdata while granted has no effect, because the values are latched.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1. No port waits for more than one other transfer.
- A request arriving in ADDR, DATA or DONE waits for the next IDLE. It is never lost while held.
- Address 0 and all-ones address pass unchanged. No arithmetic is performed on addresses.
- Reset mid-transfer:
  - Return to IDLE on the next edge and abort the transfer.
  - No ack is issued and all strobes drop.
  - rdata is cleared and last_grant returns to 1.
  - A write already strobed in DATA is not undone.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x0010 with memory[0x0010]=0xBEEF -> mem_addr_en in cycle +1, mem_out_en in cycle +2, ack0 and rdata=0xBEEF in cycle +3, busy=0 in cycle +4.
- req1=1, we1=1, addr1=0xFFFF, wdata1=0x1234 -> mem_in_en with mem_addr=0xFFFF and mem_wdata=0x1234; ack1 one cycle later; a later port 0 read of 0xFFFF returns 0x1234; rdata unchanged during the write ack.
- Both req held high for 4 transfers after reset -> grant order 0,1,0,1; gnt0 and gnt1 never high together; each ack is a single-cycle pulse.
- Port 0 issues back-to-back reads with req1 idle -> every transfer goes to port 0; ack0 every 4 cycles.
- req1 raised during a port 0 DATA state -> port 1 granted in the next IDLE; its request is not dropped.
- rst asserted in DATA of a port 1 read -> next cycle: state IDLE, ack1=0, all strobes 0, rdata=0, and port 0 wins the next contention.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the memory, and mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_addr_en;
    logic              mem_in_en;
    logic              mem_out_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, ack0, gnt1, ack1, rdata, busy,
        output mem_addr_en, mem_in_en, mem_out_en, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, ack0, gnt1, ack1, rdata, busy,
        input  mem_addr_en, mem_in_en, mem_out_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU (port 0) and DMA (port 1).
//   state | meaning
//   IDLE  | sample requests, pick winner, latch its we/addr/wdata
//   ADDR  | mem_addr_en strobe with latched address
//   DATA  | mem_in_en (write) or mem_out_en (read, rdata captured)
//   DONE  | one-cycle ack to the winner
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic              win_q;
    logic              we_q;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;
    logic              grant_vld;
    logic              grant_id;

    // On contention the port that did not win last time goes next.
    always_comb begin
        grant_vld = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1)
            grant_id = ~last_grant;
        else
            grant_id = bus.req1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = ADDR;
            ADDR:    state_nx = DATA;
            DATA:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            last_grant <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                win_q      <= grant_id;
                last_grant <= grant_id;
                we_q       <= grant_id ? bus.we1    : bus.we0;
                addr_q     <= grant_id ? bus.addr1  : bus.addr0;
                wdata_q    <= grant_id ? bus.wdata1 : bus.wdata0;
            end
            if (state == DATA && !we_q)
                rdata_q <= bus.mem_rdata;
            ack0_q <= (state_nx == DONE) && !win_q;
            ack1_q <= (state_nx == DONE) &&  win_q;
            busy_q <= (state_nx != IDLE);
        end
    end

    always_comb begin
        bus.gnt0        = (state != IDLE) && !win_q;
        bus.gnt1        = (state != IDLE) &&  win_q;
        bus.ack0        = ack0_q;
        bus.ack1        = ack1_q;
        bus.rdata       = rdata_q;
        bus.busy        = busy_q;
        bus.mem_addr_en = (state == ADDR);
        bus.mem_in_en   = (state == DATA) &&  we_q;
        bus.mem_out_en  = (state == DATA) && !we_q;
        bus.mem_addr    = (state == ADDR || state == DATA) ? addr_q  : '0;
        bus.mem_wdata   = (state == ADDR || state == DATA) ? wdata_q : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64K x 16 memory model.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    logic [15:0] mem [0:65535];

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_in_en) mem[bus.mem_addr] <= bus.mem_wdata;

    assign bus.mem_rdata = bus.mem_out_en ? mem[bus.mem_addr] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("idle_reached", {31'd0, bus.busy}, 32'd0);
    endtask

    // One complete transfer from a single port; exp_rd is the rdata expected at ack.
    task automatic xfer(input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        step();
        chk("x_addr_en",  {31'd0, bus.mem_addr_en}, 32'd1);
        chk("x_addr",     {16'd0, bus.mem_addr}, {16'd0, addr});
        chk("x_gnt",      {30'd0, bus.gnt1, bus.gnt0}, port ? 32'd2 : 32'd1);
        chk("x_busy",     {31'd0, bus.busy}, 32'd1);
        step();
        chk("x_in_en",    {31'd0, bus.mem_in_en},  {31'd0, we});
        chk("x_out_en",   {31'd0, bus.mem_out_en}, {31'd0, ~we});
        chk("x_addr_en0", {31'd0, bus.mem_addr_en}, 32'd0);
        if (we) chk("x_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
        step();
        chk("x_ack",      {30'd0, bus.ack1, bus.ack0}, port ? 32'd2 : 32'd1);
        chk("x_rdata",    {16'd0, bus.rdata}, {16'd0, exp_rd});
        chk("x_strobes",  {29'd0, bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}, 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        chk("x_done_busy", {31'd0, bus.busy}, 32'd0);
        chk("x_done_ack",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
    endtask

    initial begin
        int nack, both, dbl, n1;
        bit prev_ack;
        bit ord [4];
        int pos [3];

        n_chk = 0; n_pass = 0;
        mem[16'h0010] = 16'hBEEF;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        step(); step();
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_acks",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst_gnts",  {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        chk("rst_strb",  {29'd0, bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}, 32'd0);
        chk("rst_maddr", {16'd0, bus.mem_addr}, 32'd0);
        rst = 1'b0;

        // Basic read, then write to the all-ones address and read it back.
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        xfer(1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'hBEEF);
        xfer(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234);
        xfer(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Fairness from reset: both held for four transfers.
        rst = 1'b1; step(); rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'hFFFF;
        nack = 0; both = 0; dbl = 0; prev_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.gnt0 && bus.gnt1) both++;
            if (bus.ack0 || bus.ack1) begin
                if (prev_ack) dbl++;
                if (nack < 4) ord[nack] = bus.ack1;
                nack++;
            end
            prev_ack = bus.ack0 | bus.ack1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr_nack", nack, 4);
        chk("rr_ord0", {31'd0, ord[0]}, 32'd0);
        chk("rr_ord1", {31'd0, ord[1]}, 32'd1);
        chk("rr_ord2", {31'd0, ord[2]}, 32'd0);
        chk("rr_ord3", {31'd0, ord[3]}, 32'd1);
        chk("rr_both_gnt", both, 0);
        chk("rr_ack_pulse", dbl, 0);
        wait_idle();

        // Back-to-back port 0 reads.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        nack = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.ack1) n1++;
            if (bus.ack0) begin
                if (nack < 3) pos[nack] = i;
                nack++;
            end
        end
        bus.req0 = 1'b0;
        chk("b2b_nack", nack, 3);
        chk("b2b_first", pos[0], 2);
        chk("b2b_gap1", pos[1] - pos[0], 4);
        chk("b2b_gap2", pos[2] - pos[1], 4);
        chk("b2b_ack1", n1, 0);
        wait_idle();

        // Port 1 raises req during port 0 DATA and is served next.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
        step();
        step();
        chk("late_data0", {31'd0, bus.mem_out_en}, 32'd1);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'hFFFF;
        step();
        chk("late_ack0", {31'd0, bus.ack0}, 32'd1);
        bus.req0 = 1'b0;
        step();
        chk("late_idle", {31'd0, bus.busy}, 32'd0);
        step();
        chk("late_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        step();
        step();
        chk("late_ack1",   {31'd0, bus.ack1}, 32'd1);
        chk("late_rdata1", {16'd0, bus.rdata}, 32'h1234);
        bus.req1 = 1'b0;
        wait_idle();

        // Reset in idle restores last_grant after port 0 won last.
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        rst = 1'b1; step(); rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        chk("lg_rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();

        // Reset during DATA of a port 1 read.
        xfer(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0010;
        step();
        step();
        chk("mid_in_data", {31'd0, bus.mem_out_en}, 32'd1);
        rst = 1'b1; bus.req1 = 1'b0;
        step();
        chk("mid_busy",  {31'd0, bus.busy}, 32'd0);
        chk("mid_ack",   {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("mid_gnt",   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        chk("mid_strb",  {29'd0, bus.mem_addr_en, bus.mem_in_en, bus.mem_out_en}, 32'd0);
        chk("mid_rdata", {16'd0, bus.rdata}, 32'd0);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        chk("mid_next_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
